// File: rtl/axis_pattern_generator.sv
// AXI4-Stream test-pattern source: per-run length/start/stride/mode, one beat per cycle.
// Lane registers advance incrementally per accepted beat so no multiplier sits in the beat path.
module axis_pattern_generator #(
  parameter int C_M_AXIS_TDATA_WIDTH = 128,
  parameter int C_NUMBER_BIT_WIDTH   = 32,
  parameter int C_LENGTH_WIDTH       = 32
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_idle,
  output logic                              ap_done,
  input  logic [C_LENGTH_WIDTH-1:0]         cfg_length_bytes,
  input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_start_value,
  input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_stride,
  input  logic [1:0]                        cfg_mode,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                              m_axis_tlast
);

  localparam int W   = C_NUMBER_BIT_WIDTH;
  localparam int L   = C_M_AXIS_TDATA_WIDTH / W;
  localparam int KW  = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int LW  = C_LENGTH_WIDTH + 1;
  localparam int RW  = (KW > 1) ? $clog2(KW) : 1;
  localparam int ROT = L % W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [LW-1:0]   nb_q, nb_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic            walk_q, walk_d;
  logic [W-1:0]    step_q, step_d;
  logic [W-1:0]    lane_q [L];
  logic [W-1:0]    lane_d [L];

  logic [LW-1:0]   len_ext;
  logic [LW-1:0]   nb_calc;
  logic [RW-1:0]   rem_calc;
  logic            last_beat;

  // One extra bit keeps len + BPB-1 from wrapping before the divide.
  assign len_ext   = {1'b0, cfg_length_bytes};
  assign nb_calc   = (len_ext + LW'(KW - 1)) / LW'(KW);
  assign rem_calc  = RW'(len_ext % LW'(KW));
  assign last_beat = (beat_q == nb_q - LW'(1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      nb_q    <= '0;
      rem_q   <= '0;
      walk_q  <= 1'b0;
      step_q  <= '0;
      for (int i = 0; i < L; i++) lane_q[i] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      nb_q    <= nb_d;
      rem_q   <= rem_d;
      walk_q  <= walk_d;
      step_q  <= step_d;
      for (int i = 0; i < L; i++) lane_q[i] <= lane_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    nb_d    = nb_q;
    rem_d   = rem_q;
    walk_d  = walk_q;
    step_d  = step_q;
    for (int i = 0; i < L; i++) lane_d[i] = lane_q[i];
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = (nb_calc == '0) ? S_DONE : S_RUN;
          beat_d  = '0;
          nb_d    = nb_calc;
          rem_d   = rem_calc;
          walk_d  = (cfg_mode == 2'd2);
          // Constant mode is an increment with a zero step.
          step_d  = (cfg_mode == 2'd1) ? '0 : W'(L) * cfg_stride;
          for (int i = 0; i < L; i++) begin
            case (cfg_mode)
              2'd1:    lane_d[i] = cfg_start_value;
              2'd2:    lane_d[i] = W'(1) << (i % W);
              default: lane_d[i] = cfg_start_value + W'(i) * cfg_stride;
            endcase
          end
        end
      end
      S_RUN: begin
        if (m_axis_tready) begin
          beat_d = beat_q + LW'(1);
          // Walking-one advances by L elements: a rotate by L mod W.
          for (int i = 0; i < L; i++)
            lane_d[i] = walk_q ? ((lane_q[i] << ROT) | (lane_q[i] >> (W - ROT)))
                               : lane_q[i] + step_q;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ap_idle       = (state_q == S_IDLE);
  assign ap_done       = (state_q == S_DONE);
  assign m_axis_tvalid = (state_q == S_RUN);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    if (m_axis_tvalid) begin
      for (int i = 0; i < L; i++) m_axis_tdata[i*W +: W] = lane_q[i];
      if (last_beat && rem_q != '0)
        m_axis_tkeep = {KW{1'b1}} >> (KW - int'(rem_q));
      else
        m_axis_tkeep = {KW{1'b1}};
    end
  end

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Bench for axis_pattern_generator: expected beats are queued at run start and
// compared as the DUT hands them off; done timing, stalls and reset abort are checked.
module tb_axis_pattern_generator;

  logic         aclk = 1'b0;
  logic         areset;
  logic         ap_start;
  logic         ap_idle;
  logic         ap_done;
  logic [31:0]  cfg_length_bytes;
  logic [31:0]  cfg_start_value;
  logic [31:0]  cfg_stride;
  logic [1:0]   cfg_mode;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast;

  axis_pattern_generator dut (
    .aclk             (aclk),
    .areset           (areset),
    .ap_start         (ap_start),
    .ap_idle          (ap_idle),
    .ap_done          (ap_done),
    .cfg_length_bytes (cfg_length_bytes),
    .cfg_start_value  (cfg_start_value),
    .cfg_stride       (cfg_stride),
    .cfg_mode         (cfg_mode),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t  sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     hs_cnt = 0;
  int     last_hs_cyc = 0;
  bit     rand_rdy = 1'b0;
  bit     prev_stall = 1'b0;
  beat_t  prev_beat;

  task automatic chk_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_val(input logic [31:0] start, input logic [31:0] stride,
                                           input logic [1:0] mode, input int e);
    case (mode)
      2'd1:    return start;
      2'd2:    return 32'd1 << (e % 32);
      default: return start + 32'(e) * stride;
    endcase
  endfunction

  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    m_axis_tready = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Output monitor: scoreboard pops on handshake, stability on stall, zeros when invalid.
  always @(negedge aclk) begin
    beat_t exp_b;
    if (!areset) begin
      if (prev_stall) begin
        chk_eq("valid_held", m_axis_tvalid, 1'b1);
        chk_eq("stall_stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, prev_beat);
      end
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          if (sb_q.size() == 0) begin
            chk_eq("sb_underflow", sb_q.size(), 1);
          end else begin
            exp_b = sb_q.pop_front();
            chk_eq("tdata", m_axis_tdata, exp_b.d);
            chk_eq("tkeep", m_axis_tkeep, exp_b.k);
            chk_eq("tlast", m_axis_tlast, exp_b.l);
          end
          hs_cnt++;
          last_hs_cyc = cyc;
        end
      end else begin
        chk_eq("idle_outs_zero", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, '0);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_run(input int len, input logic [31:0] start, input logic [31:0] stride,
                           input logic [1:0] mode, input bit rnd, output int accept_cyc);
    int    nb, r;
    beat_t b_exp;
    nb = (len + 15) / 16;
    r  = len % 16;
    for (int b = 0; b < nb; b++) begin
      b_exp.d = '0;
      for (int i = 0; i < 4; i++) b_exp.d[i*32 +: 32] = lane_val(start, stride, mode, b*4 + i);
      b_exp.l = (b == nb - 1);
      b_exp.k = (b == nb - 1 && r != 0) ? (16'hFFFF >> (16 - r)) : 16'hFFFF;
      sb_q.push_back(b_exp);
    end
    @(posedge aclk); #1;
    rand_rdy         = rnd;
    cfg_length_bytes = len;
    cfg_start_value  = start;
    cfg_stride       = stride;
    cfg_mode         = mode;
    ap_start         = 1'b1;
    accept_cyc       = cyc;
    @(posedge aclk); #1;
    ap_start = 1'b0;
    chk_eq("idle_low", ap_idle, 1'b0);
    // Config changes mid-run must be ignored.
    cfg_length_bytes = $urandom;
    cfg_start_value  = $urandom;
    cfg_stride       = $urandom;
    cfg_mode         = 2'($urandom);
  endtask

  task automatic run(input int len, input logic [31:0] start, input logic [31:0] stride,
                     input logic [1:0] mode, input bit rnd);
    int accept_cyc, hs0, guard, nb;
    nb  = (len + 15) / 16;
    hs0 = hs_cnt;
    start_run(len, start, stride, mode, rnd, accept_cyc);
    guard = 0;
    do begin
      @(negedge aclk);
      guard++;
    end while (!ap_done && guard < 5000);
    chk_eq("done_seen", ap_done, 1'b1);
    chk_eq("done_time", cyc, ((nb == 0) ? accept_cyc : last_hs_cyc) + 1);
    chk_eq("hs_count", hs_cnt - hs0, nb);
    chk_eq("sb_empty", sb_q.size(), 0);
    @(negedge aclk);
    chk_eq("done_pulse", ap_done, 1'b0);
    chk_eq("idle_back", ap_idle, 1'b1);
    rand_rdy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, hs0, guard;
    areset           = 1'b1;
    ap_start         = 1'b0;
    cfg_length_bytes = '0;
    cfg_start_value  = '0;
    cfg_stride       = '0;
    cfg_mode         = '0;
    m_axis_tready    = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    chk_eq("rst_idle", ap_idle, 1'b1);
    chk_eq("rst_done", ap_done, 1'b0);
    chk_eq("rst_outs", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, '0);
    areset = 1'b0;

    run(64, 32'd0, 32'd1, 2'd0, 1'b0);
    run(20, 32'd0, 32'd1, 2'd0, 1'b0);
    run(0, 32'd0, 32'd1, 2'd0, 1'b0);
    run(256, 32'd7, 32'd5, 2'd0, 1'b1);
    run(40, 32'hFFFF_FFFE, 32'd1, 2'd0, 1'b0);
    run(48, 32'hA5A5_A5A5, 32'd3, 2'd1, 1'b0);
    run(160, 32'd0, 32'd1, 2'd2, 1'b0);
    run(33, 32'd100, 32'h1000_0001, 2'd3, 1'b1);
    run(17, 32'd9, 32'd2, 2'd2, 1'b1);

    // Abort after two of eight beats.
    hs0 = hs_cnt;
    start_run(128, 32'd0, 32'd1, 2'd0, 1'b0, acc);
    guard = 0;
    while (hs_cnt - hs0 < 2 && guard < 100) begin
      @(posedge aclk); #1;
      guard++;
    end
    chk_eq("abort_hs", hs_cnt - hs0, 2);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk_eq("abort_tvalid", m_axis_tvalid, 1'b0);
    chk_eq("abort_idle", ap_idle, 1'b1);
    chk_eq("abort_done", ap_done, 1'b0);
    areset = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk_eq("abort_no_done", ap_done, 1'b0);
    end
    run(32, 32'd0, 32'd1, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
